// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states, opcodes, funct codes,
// ALU operations and datapath mux selects.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    StIf  = 4'd0,
    StDcd = 4'd1,
    StExr = 4'd2,
    StWbr = 4'd3,
    StExi = 4'd4,
    StWbi = 4'd5,
    StMa  = 4'd6,
    StMr  = 4'd7,
    StWbm = 4'd8,
    StMw  = 4'd9,
    StBr  = 4'd10,
    StJmp = 4'd11
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpAddiu = 6'b001001;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpLui   = 6'b001111;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpJal   = 6'b000011;

  localparam logic [5:0] FnAddu = 6'b100001;
  localparam logic [5:0] FnSubu = 6'b100011;
  localparam logic [5:0] FnAnd  = 6'b100100;
  localparam logic [5:0] FnOr   = 6'b100101;
  localparam logic [5:0] FnSlt  = 6'b101010;

  localparam logic [2:0] AluAdd = 3'd0;
  localparam logic [2:0] AluSub = 3'd1;
  localparam logic [2:0] AluAnd = 3'd2;
  localparam logic [2:0] AluOr  = 3'd3;
  localparam logic [2:0] AluSlt = 3'd4;
  localparam logic [2:0] AluLui = 3'd5;

  localparam logic [1:0] NpcPc4    = 2'd0;
  localparam logic [1:0] NpcBranch = 2'd1;
  localparam logic [1:0] NpcJump   = 2'd2;

  localparam logic       AluAPc = 1'b0;
  localparam logic       AluARs = 1'b1;

  localparam logic [1:0] AluBRt    = 2'd0;
  localparam logic [1:0] AluBFour  = 2'd1;
  localparam logic [1:0] AluBImm   = 2'd2;
  localparam logic [1:0] AluBBrOff = 2'd3;

  localparam logic [1:0] RegDstRt = 2'd0;
  localparam logic [1:0] RegDstRd = 2'd1;
  localparam logic [1:0] RegDstRa = 2'd2;

  localparam logic [1:0] WdAluOut = 2'd0;
  localparam logic [1:0] WdMdr    = 2'd1;
  localparam logic [1:0] WdPc     = 2'd2;

endpackage

// File: rtl/mc_alu_dec.sv
// Combinational ALU-operation decoder: maps opcode/funct to an ALU code and flags
// whether the instruction is one this control unit supports.
module mc_alu_dec
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alu_ctl_o,
  output logic       valid_o
);

  always_comb begin
    alu_ctl_o = AluAdd;
    valid_o   = 1'b1;
    case (op_i)
      OpRtype: begin
        case (funct_i)
          FnAddu:  alu_ctl_o = AluAdd;
          FnSubu:  alu_ctl_o = AluSub;
          FnAnd:   alu_ctl_o = AluAnd;
          FnOr:    alu_ctl_o = AluOr;
          FnSlt:   alu_ctl_o = AluSlt;
          default: valid_o   = 1'b0;
        endcase
      end
      OpAddiu, OpLw, OpSw, OpJ, OpJal: alu_ctl_o = AluAdd;
      OpOri:   alu_ctl_o = AluOr;
      OpLui:   alu_ctl_o = AluLui;
      OpBeq:   alu_ctl_o = AluSub;
      default: valid_o   = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle MIPS control FSM; outputs are a decode of the current state.
// Define MC_CTRL_MEM_WAIT_EN to make IF/MR/MW wait for mem_rdy.
module mc_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_rdy,
  output logic       pc_wr,
  output logic       ir_wr,
  output logic       reg_wr,
  output logic       mem_req,
  output logic       mem_wr,
  output logic [1:0] npc_sel,
  output logic       alu_a,
  output logic [1:0] alu_b,
  output logic       ext_z,
  output logic [2:0] alu_ctl,
  output logic [1:0] reg_dst,
  output logic [1:0] wd_sel,
  output logic       instr_err,
  output logic [3:0] state
);

`ifdef MC_CTRL_MEM_WAIT_EN
  localparam bit WaitEn = 1'b1;
`else
  localparam bit WaitEn = 1'b0;
`endif

  state_e     state_q, state_d;
  logic [2:0] dec_alu_ctl;
  logic       dec_valid;
  logic       mem_go;

  mc_alu_dec u_alu_dec (
    .op_i      (op),
    .funct_i   (funct),
    .alu_ctl_o (dec_alu_ctl),
    .valid_o   (dec_valid)
  );

  // Without the wait feature every memory access completes in one cycle.
  assign mem_go = mem_rdy | ~WaitEn;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIf: if (mem_go) state_d = StDcd;
      StDcd: begin
        case (op)
          OpRtype:               state_d = StExr;
          OpAddiu, OpOri, OpLui: state_d = StExi;
          OpLw, OpSw:            state_d = StMa;
          OpBeq:                 state_d = StBr;
          OpJ, OpJal:            state_d = StJmp;
          default:               state_d = StIf;
        endcase
      end
      StExr:  state_d = dec_valid ? StWbr : StIf;
      StExi:  state_d = StWbi;
      StMa:   state_d = (op == OpLw) ? StMr : StMw;
      StMr:   if (mem_go) state_d = StWbm;
      StMw:   if (mem_go) state_d = StIf;
      default: state_d = StIf;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIf;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    pc_wr     = 1'b0;
    ir_wr     = 1'b0;
    reg_wr    = 1'b0;
    mem_req   = 1'b0;
    mem_wr    = 1'b0;
    npc_sel   = NpcPc4;
    alu_a     = AluAPc;
    alu_b     = AluBRt;
    ext_z     = 1'b0;
    alu_ctl   = AluAdd;
    reg_dst   = RegDstRt;
    wd_sel    = WdAluOut;
    instr_err = 1'b0;
    case (state_q)
      StIf: begin
        mem_req = 1'b1;
        alu_b   = AluBFour;
        pc_wr   = mem_go;
        ir_wr   = mem_go;
      end
      StDcd: begin
        alu_b     = AluBBrOff;
        instr_err = (op != OpRtype) && !dec_valid;
      end
      StExr: begin
        alu_a     = AluARs;
        alu_ctl   = dec_alu_ctl;
        instr_err = !dec_valid;
      end
      StWbr: begin
        reg_wr  = 1'b1;
        reg_dst = RegDstRd;
      end
      StExi: begin
        alu_a   = AluARs;
        alu_b   = AluBImm;
        alu_ctl = dec_alu_ctl;
        ext_z   = (op == OpOri);
      end
      StWbi: reg_wr = 1'b1;
      StMa: begin
        alu_a = AluARs;
        alu_b = AluBImm;
      end
      StMr: mem_req = 1'b1;
      StWbm: begin
        reg_wr = 1'b1;
        wd_sel = WdMdr;
      end
      StMw: begin
        mem_req = 1'b1;
        mem_wr  = 1'b1;
      end
      StBr: begin
        alu_a   = AluARs;
        alu_ctl = AluSub;
        npc_sel = NpcBranch;
        pc_wr   = zero;
      end
      StJmp: begin
        npc_sel = NpcJump;
        pc_wr   = 1'b1;
        if (op == OpJal) begin
          reg_wr  = 1'b1;
          reg_dst = RegDstRa;
          wd_sel  = WdPc;
        end
      end
      default: ;
    endcase
    // Reset kills every strobe immediately, including those IF would otherwise drive.
    if (!rst_n) begin
      pc_wr     = 1'b0;
      ir_wr     = 1'b0;
      reg_wr    = 1'b0;
      mem_req   = 1'b0;
      mem_wr    = 1'b0;
      npc_sel   = NpcPc4;
      alu_a     = AluAPc;
      alu_b     = AluBRt;
      ext_z     = 1'b0;
      alu_ctl   = AluAdd;
      reg_dst   = RegDstRt;
      wd_sel    = WdAluOut;
      instr_err = 1'b0;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: hand-computed state sequences and strobes per instruction class.
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_rdy;
  logic       pc_wr, ir_wr, reg_wr, mem_req, mem_wr, alu_a, ext_z, instr_err;
  logic [1:0] npc_sel, alu_b, reg_dst, wd_sel;
  logic [2:0] alu_ctl;
  logic [3:0] state;

  int checks   = 0;
  int failures = 0;

  mc_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op        (op),
    .funct     (funct),
    .zero      (zero),
    .mem_rdy   (mem_rdy),
    .pc_wr     (pc_wr),
    .ir_wr     (ir_wr),
    .reg_wr    (reg_wr),
    .mem_req   (mem_req),
    .mem_wr    (mem_wr),
    .npc_sel   (npc_sel),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .ext_z     (ext_z),
    .alu_ctl   (alu_ctl),
    .reg_dst   (reg_dst),
    .wd_sel    (wd_sel),
    .instr_err (instr_err),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // All 23 output bits concatenated; zero means every output is low.
  function automatic logic [31:0] all_outs();
    return {9'd0, pc_wr, ir_wr, reg_wr, mem_req, mem_wr, npc_sel, alu_a, alu_b, ext_z,
            alu_ctl, reg_dst, wd_sel, instr_err, state};
  endfunction

  initial begin
    rst_n   = 1'b1;
    op      = 6'b100011;
    funct   = 6'b000000;
    zero    = 1'b0;
    mem_rdy = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) cyc();
    chk("reset_outs", all_outs(), 32'd0);
    chk("reset_state", state, 4'd0);

    // addu: IF DCD EXR WBR
    rst_n = 1'b1;
    op    = 6'b000000;
    funct = 6'b100001;
    #1;
    chk("if_pcwr", pc_wr, 1'b1);
    chk("if_irwr", ir_wr, 1'b1);
    chk("if_memreq", mem_req, 1'b1);
    chk("if_alub", alu_b, 2'd1);
    cyc();
    chk("addu_dcd_state", state, 4'd1);
    chk("addu_dcd_alub", alu_b, 2'd3);
    chk("addu_dcd_pcwr", pc_wr, 1'b0);
    cyc();
    chk("addu_exr_state", state, 4'd2);
    chk("addu_exr_aluctl", alu_ctl, 3'd0);
    chk("addu_exr_alua", alu_a, 1'b1);
    cyc();
    chk("addu_wbr_state", state, 4'd3);
    chk("addu_wbr_regwr", reg_wr, 1'b1);
    chk("addu_wbr_regdst", reg_dst, 2'd1);
    cyc();
    chk("addu_done_state", state, 4'd0);

    // lw: IF DCD MA MR WBM
    op = 6'b100011;
    cyc();
    cyc();
    chk("lw_ma_state", state, 4'd6);
    chk("lw_ma_alub", alu_b, 2'd2);
    cyc();
    chk("lw_mr_state", state, 4'd7);
    chk("lw_mr_memreq", mem_req, 1'b1);
    chk("lw_mr_memwr", mem_wr, 1'b0);
    cyc();
    chk("lw_wbm_state", state, 4'd8);
    chk("lw_wbm_wdsel", wd_sel, 2'd1);
    chk("lw_wbm_regwr", reg_wr, 1'b1);
    cyc();
    chk("lw_done_state", state, 4'd0);

    // sw: IF DCD MA MW
    op = 6'b101011;
    cyc();
    cyc();
    cyc();
    chk("sw_mw_state", state, 4'd9);
    chk("sw_mw_memreq", mem_req, 1'b1);
    chk("sw_mw_memwr", mem_wr, 1'b1);
    cyc();
    chk("sw_done_state", state, 4'd0);

    // beq taken then not taken
    op   = 6'b000100;
    zero = 1'b1;
    cyc();
    cyc();
    chk("beq1_br_state", state, 4'd10);
    chk("beq1_pcwr", pc_wr, 1'b1);
    chk("beq1_npcsel", npc_sel, 2'd1);
    chk("beq1_aluctl", alu_ctl, 3'd1);
    cyc();
    chk("beq1_done_state", state, 4'd0);
    zero = 1'b0;
    cyc();
    cyc();
    chk("beq0_br_state", state, 4'd10);
    chk("beq0_pcwr", pc_wr, 1'b0);
    cyc();
    chk("beq0_done_state", state, 4'd0);

    // jal
    op = 6'b000011;
    cyc();
    cyc();
    chk("jal_state", state, 4'd11);
    chk("jal_pcwr", pc_wr, 1'b1);
    chk("jal_npcsel", npc_sel, 2'd2);
    chk("jal_regwr", reg_wr, 1'b1);
    chk("jal_regdst", reg_dst, 2'd2);
    chk("jal_wdsel", wd_sel, 2'd2);
    cyc();
    chk("jal_done_state", state, 4'd0);

    // ori: EXI with zero-extend, then WBI
    op = 6'b001101;
    cyc();
    cyc();
    chk("ori_exi_state", state, 4'd4);
    chk("ori_exi_extz", ext_z, 1'b1);
    chk("ori_exi_aluctl", alu_ctl, 3'd3);
    cyc();
    chk("ori_wbi_state", state, 4'd5);
    chk("ori_wbi_regwr", reg_wr, 1'b1);
    chk("ori_wbi_regdst", reg_dst, 2'd0);
    cyc();

    // unsupported opcode: error pulse in DCD, 2-cycle latency
    op = 6'b111111;
    cyc();
    chk("badop_dcd_err", instr_err, 1'b1);
    chk("badop_dcd_state", state, 4'd1);
    cyc();
    chk("badop_back_state", state, 4'd0);
    chk("badop_err_clear", instr_err, 1'b0);

    // unsupported funct: error pulse in EXR only
    op    = 6'b000000;
    funct = 6'b000000;
    cyc();
    chk("badfn_dcd_err", instr_err, 1'b0);
    cyc();
    chk("badfn_exr_err", instr_err, 1'b1);
    cyc();
    chk("badfn_back_state", state, 4'd0);
    funct = 6'b100001;

`ifdef MC_CTRL_MEM_WAIT_EN
    // IF stalls two cycles on mem_rdy
    mem_rdy = 1'b0;
    #1;
    chk("wait_if1_memreq", mem_req, 1'b1);
    chk("wait_if1_pcwr", pc_wr, 1'b0);
    cyc();
    chk("wait_if2_state", state, 4'd0);
    chk("wait_if2_memreq", mem_req, 1'b1);
    chk("wait_if2_irwr", ir_wr, 1'b0);
    cyc();
    mem_rdy = 1'b1;
    #1;
    chk("wait_if3_pcwr", pc_wr, 1'b1);
    chk("wait_if3_irwr", ir_wr, 1'b1);
    cyc();
    chk("wait_dcd_state", state, 4'd1);
    cyc();
    cyc();
    cyc();
`endif

    // reset asserted while in MR
    op = 6'b100011;
    cyc();
    cyc();
    cyc();
    chk("abort_mr_state", state, 4'd7);
    rst_n = 1'b0;
    #1;
    chk("abort_outs", all_outs(), 32'd0);
    cyc();
    rst_n = 1'b1;
    #1;
    chk("abort_restart_state", state, 4'd0);
    chk("abort_restart_pcwr", pc_wr, 1'b1);
    cyc();
    chk("abort_dcd_state", state, 4'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
